// File: rtl/vector_alu_pkg.sv
// Shared definitions for the lane-parallel add/subtract pipeline.
package vector_alu_pkg;

    // Operation select carried alongside each operand set.
    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,   // wrap-around add, flag = carry out
        MODE_SUB  = 2'b01,   // wrap-around A-B, flag = borrow
        MODE_ADDS = 2'b10,   // unsigned saturating add
        MODE_SUBS = 2'b11    // unsigned saturating subtract
    } mode_e;

    localparam int DEF_LANES  = 24;
    localparam int DEF_LANE_W = 8;
    localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/addsub_lane.sv
// One independent lane: add or subtract with wrap or unsigned saturation.
// Purely combinational; the carry/borrow never leaves the lane.
module addsub_lane
    import vector_alu_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  mode_e             mode,
    output logic [LANE_W-1:0] y,
    output logic              flag
);

    // One extra bit captures carry (add) or borrow (sub, set when a < b).
    logic [LANE_W:0] sum;
    logic [LANE_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Select the lane result and its carry/borrow/clamp flag.
    always_comb begin
        y    = sum[LANE_W-1:0];
        flag = sum[LANE_W];
        case (mode)
            MODE_ADD: begin
                y    = sum[LANE_W-1:0];
                flag = sum[LANE_W];
            end
            MODE_SUB: begin
                y    = diff[LANE_W-1:0];
                flag = diff[LANE_W];
            end
            MODE_ADDS: begin
                flag = sum[LANE_W];
                y    = sum[LANE_W] ? {LANE_W{1'b1}} : sum[LANE_W-1:0];
            end
            MODE_SUBS: begin
                flag = diff[LANE_W];
                y    = diff[LANE_W] ? {LANE_W{1'b0}} : diff[LANE_W-1:0];
            end
            default: begin
                y    = sum[LANE_W-1:0];
                flag = sum[LANE_W];
            end
        endcase
    end

endmodule

// File: rtl/vector_addsub_pipe.sv
// Two-stage valid/ready pipeline applying addsub_lane across LANES lanes.
// S1 holds operands and mode, S2 holds lane results and flags; S2 drives
// the outputs directly. ops_done counts results accepted downstream.
module vector_addsub_pipe
    import vector_alu_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*LANE_W-1:0]   op1,
    input  logic [LANES*LANE_W-1:0]   op2,
    input  logic [1:0]                mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   result,
    output logic [LANES-1:0]          sat_flags,
    output logic [CNT_W-1:0]          ops_done
);

    localparam int VW = LANES * LANE_W;

    logic              s1_valid;
    logic [VW-1:0]     s1_a;
    logic [VW-1:0]     s1_b;
    mode_e             s1_mode;

    logic              s2_valid;
    logic [VW-1:0]     s2_result;
    logic [LANES-1:0]  s2_flags;

    logic [VW-1:0]     lane_y;
    logic [LANES-1:0]  lane_flag;

    logic              s2_load;
    logic              accept;
    logic [CNT_W-1:0]  cnt;

    // S2 may take new contents when empty or when its result leaves now.
    // S1 can accept when empty or when its contents move into S2 now.
    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign accept   = in_valid && in_ready;

    // S1 valid bit: refills on accept, empties when it advances without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // S1 operand/mode capture; data needs no reset since s1_valid guards it.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a    <= op1;
            s1_b    <= op2;
            s1_mode <= mode_e'(mode);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            addsub_lane #(
                .LANE_W (LANE_W)
            ) u_lane (
                .a    (s1_a[gi*LANE_W +: LANE_W]),
                .b    (s1_b[gi*LANE_W +: LANE_W]),
                .mode (s1_mode),
                .y    (lane_y[gi*LANE_W +: LANE_W]),
                .flag (lane_flag[gi])
            );
        end
    endgenerate

    // S2 register: loads lane results while free; held stable when stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= lane_y;
                s2_flags  <= lane_flag;
            end
        end
    end

    // Completed-operation counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (s2_valid && out_ready) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign out_valid = s2_valid;
    assign result    = s2_result;
    assign sat_flags = s2_flags;
    assign ops_done  = cnt;

endmodule

// File: tb/tb_vector_addsub_pipe.sv
// Directed bench: lane table on the default 24x8 build, a 4x16 build with a
// narrow counter for wrap, plus stall-stream and reset-in-flight sequences.
module tb_vector_addsub_pipe;

    logic clk;
    logic rst;

    // Default instance (24 lanes x 8 bits)
    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [191:0]  a_op1, a_op2, a_result;
    logic [1:0]    a_mode;
    logic [23:0]   a_flags;
    logic [15:0]   a_ops;

    // Wide-lane instance (4 lanes x 16 bits, 3-bit counter)
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0]   b_op1, b_op2, b_result;
    logic [1:0]    b_mode;
    logic [3:0]    b_flags;
    logic [2:0]    b_ops;

    vector_addsub_pipe u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .op1       (a_op1),
        .op2       (a_op2),
        .mode      (a_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .result    (a_result),
        .sat_flags (a_flags),
        .ops_done  (a_ops)
    );

    vector_addsub_pipe #(
        .LANES  (4),
        .LANE_W (16),
        .CNT_W  (3)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .op1       (b_op1),
        .op2       (b_op2),
        .mode      (b_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .result    (b_result),
        .sat_flags (b_flags),
        .ops_done  (b_ops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Even lanes use (ae,be), odd lanes use (ao,bo); expectations hand-computed.
    typedef struct {
        logic [1:0] mode;
        logic [7:0] ae, be, ao, bo;
        logic [7:0] ye;
        logic       fe;
        logic [7:0] yo;
        logic       fo;
    } vec8_t;

    // Uniform across all four 16-bit lanes.
    typedef struct {
        logic [1:0]  mode;
        logic [15:0] a, b, y;
        logic        f;
    } vec16_t;

    vec8_t  tbl[9];
    vec16_t tblb[5];

    int tests = 0;
    int fails = 0;
    int exp_a_ops = 0;
    int exp_b_ops = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] rep8(input logic [7:0] e, input logic [7:0] o);
        logic [191:0] r;
        for (int i = 0; i < 24; i++) r[i*8 +: 8] = (i % 2 == 1) ? o : e;
        return r;
    endfunction

    function automatic logic [23:0] repf(input logic e, input logic o);
        logic [23:0] r;
        for (int i = 0; i < 24; i++) r[i] = (i % 2 == 1) ? o : e;
        return r;
    endfunction

    function automatic logic [63:0] rep16(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_a_ops = 0;
        exp_b_ops = 0;
    endtask

    // Single vector through DUT A with exact 2-cycle latency check.
    task automatic run_a(input vec8_t v, input int idx);
        @(negedge clk);
        a_op1 = rep8(v.ae, v.ao);
        a_op2 = rep8(v.be, v.bo);
        a_mode = v.mode;
        a_in_valid = 1'b1;
        a_out_ready = 1'b1;
        #1;
        chk($sformatf("v%0d_in_ready", idx), a_in_ready, 1'b1);
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_latency1_out_valid", idx), a_out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_out_valid", idx), a_out_valid, 1'b1);
        chk($sformatf("v%0d_result", idx), a_result, rep8(v.ye, v.yo));
        chk($sformatf("v%0d_flags", idx), a_flags, repf(v.fe, v.fo));
        chk($sformatf("v%0d_ops_done", idx), a_ops, exp_a_ops[15:0]);
        exp_a_ops++;
    endtask

    task automatic run_b(input vec16_t v, input int idx);
        @(negedge clk);
        b_op1 = rep16(v.a);
        b_op2 = rep16(v.b);
        b_mode = v.mode;
        b_in_valid = 1'b1;
        b_out_ready = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        chk($sformatf("b%0d_latency1_out_valid", idx), b_out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk($sformatf("b%0d_out_valid", idx), b_out_valid, 1'b1);
        chk($sformatf("b%0d_result", idx), b_result, rep16(v.y));
        chk($sformatf("b%0d_flags", idx), b_flags, {4{v.f}});
        chk($sformatf("b%0d_ops_done", idx), b_ops, exp_b_ops[2:0]);
        exp_b_ops++;
    endtask

    initial begin
        //            mode   ae     be     ao     bo     ye    fe    yo    fo
        tbl[0] = '{2'b00, 8'hF0, 8'h20, 8'hF0, 8'h20, 8'h10, 1'b1, 8'h10, 1'b1};
        tbl[1] = '{2'b11, 8'd5,  8'd9,  8'd9,  8'd5,  8'd0,  1'b1, 8'd4,  1'b0};
        tbl[2] = '{2'b10, 8'd200,8'd100,8'd10, 8'd20, 8'd255,1'b1, 8'd30, 1'b0};
        tbl[3] = '{2'b00, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'h00, 1'b1, 8'h00, 1'b1};
        tbl[4] = '{2'b01, 8'd5,  8'd9,  8'd9,  8'd5,  8'hFC, 1'b1, 8'd4,  1'b0};
        tbl[5] = '{2'b10, 8'hFF, 8'h00, 8'h80, 8'h7F, 8'hFF, 1'b0, 8'hFF, 1'b0};
        tbl[6] = '{2'b11, 8'd9,  8'd9,  8'h00, 8'h01, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[7] = '{2'b01, 8'h00, 8'h00, 8'h80, 8'h01, 8'h00, 1'b0, 8'h7F, 1'b0};
        tbl[8] = '{2'b00, 8'h7F, 8'h01, 8'h80, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

        tblb[0] = '{2'b00, 16'hFFF0, 16'h0020, 16'h0010, 1'b1};
        tblb[1] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        tblb[2] = '{2'b11, 16'h0005, 16'h0009, 16'h0000, 1'b1};
        tblb[3] = '{2'b10, 16'hC800, 16'h6400, 16'hFFFF, 1'b1};
        tblb[4] = '{2'b01, 16'h1234, 16'h0034, 16'h1200, 1'b0};

        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_op1 = '0; a_op2 = '0; a_mode = 2'b00;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_op1 = '0; b_op2 = '0; b_mode = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_result", a_result, 192'd0);
        chk("rst_flags", a_flags, 24'd0);
        chk("rst_ops_done", a_ops, 16'd0);
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_b_out_valid", b_out_valid, 1'b0);

        for (int i = 0; i < 9; i++) run_a(tbl[i], i);
        @(negedge clk);
        #1;
        chk("table_ops_done", a_ops, 16'd9);

        // 9 results through a 3-bit counter: wraps 7 -> 0, ends at 1.
        for (int i = 0; i < 9; i++) run_b(tblb[i % 5], i);
        @(negedge clk);
        #1;
        chk("b_ops_done_wrap", b_ops, 3'd1);

        // Back-to-back stream of 5 with downstream stalled on cycles 3..5.
        do_reset();
        begin
            int sent = 0;
            int recv = 0;
            bit stalled_prev = 0;
            bit saw_drop = 0;
            logic [191:0] prev_res;
            logic [23:0]  prev_flg;
            prev_res = '0;
            prev_flg = '0;
            for (int c = 0; c < 40 && recv < 5; c++) begin
                @(negedge clk);
                a_out_ready = !(c >= 3 && c <= 5);
                if (sent < 5) begin
                    a_op1 = rep8(tbl[sent].ae, tbl[sent].ao);
                    a_op2 = rep8(tbl[sent].be, tbl[sent].bo);
                    a_mode = tbl[sent].mode;
                    a_in_valid = 1'b1;
                end else begin
                    a_in_valid = 1'b0;
                end
                #1;
                if (stalled_prev) begin
                    chk($sformatf("stall_c%0d_out_valid", c), a_out_valid, 1'b1);
                    chk($sformatf("stall_c%0d_result", c), a_result, prev_res);
                    chk($sformatf("stall_c%0d_flags", c), a_flags, prev_flg);
                end
                if (a_in_valid && !a_in_ready) saw_drop = 1;
                if (a_out_valid && a_out_ready) begin
                    chk($sformatf("stream%0d_result", recv), a_result,
                        rep8(tbl[recv].ye, tbl[recv].yo));
                    chk($sformatf("stream%0d_flags", recv), a_flags,
                        repf(tbl[recv].fe, tbl[recv].fo));
                    recv++;
                end
                stalled_prev = a_out_valid && !a_out_ready;
                prev_res = a_result;
                prev_flg = a_flags;
                if (a_in_valid && a_in_ready) sent++;
            end
            @(negedge clk);
            a_in_valid = 1'b0;
            a_out_ready = 1'b1;
            #1;
            chk("stream_received", recv, 5);
            chk("stream_in_ready_dropped", saw_drop, 1'b1);
            chk("stream_ops_done", a_ops, 16'd5);
        end

        // Reset with two vectors in flight (S1 and S2 both full, stalled).
        @(negedge clk);
        a_out_ready = 1'b0;
        a_op1 = rep8(8'h11, 8'h22); a_op2 = rep8(8'h01, 8'h02); a_mode = 2'b00;
        a_in_valid = 1'b1;
        @(negedge clk);
        a_op1 = rep8(8'h33, 8'h44);
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        chk("inflight_out_valid", a_out_valid, 1'b1);
        chk("inflight_in_ready", a_in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", a_out_valid, 1'b0);
        chk("midrst_ops_done", a_ops, 16'd0);
        chk("midrst_result", a_result, 192'd0);
        chk("midrst_in_ready", a_in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        a_out_ready = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                #1;
                if (a_out_valid) seen++;
            end
            chk("midrst_no_stale_out", seen, 0);
            chk("midrst_ops_after", a_ops, 16'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time limit so the run always reaches a conclusion.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
